// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit producing the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, one step per clock.
module mul_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_MDU_srcA,
  input  logic [DATA_W-1:0] i_MDU_srcB,
  input  logic [2:0]        i_MDU_op,
  input  logic              i_MDU_start,
  output logic              o_MDU_busy,
  output logic              o_MDU_done,
  output logic [DATA_W-1:0] o_MDU_hi,
  output logic [DATA_W-1:0] o_MDU_lo
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_is_div;
  logic                  r_neg_res;
  logic                  r_neg_rem;
  logic                  r_div_zero;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic [DATA_W-1:0]     r_opd;
  logic [DATA_W-1:0]     r_raw_a;
  logic [2*DATA_W-1:0]   r_acc;

  logic                  w_accept;
  logic                  w_is_div_op;
  logic                  w_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_W-1:0]     w_mag_a;
  logic [DATA_W-1:0]     w_mag_b;
  logic [DATA_W:0]       w_add;
  logic [DATA_W:0]       w_rem_sh;
  logic                  w_ge;
  logic [DATA_W-1:0]     w_diff;
  logic [2*DATA_W-1:0]   w_acc_next;
  logic [2*DATA_W-1:0]   w_prod;
  logic [DATA_W-1:0]     w_res_hi;
  logic [DATA_W-1:0]     w_res_lo;

  assign w_accept    = i_MDU_start && (r_state == S_IDLE) &&
                       (i_MDU_op >= OP_MULT) && (i_MDU_op <= OP_DIVU);
  assign w_is_div_op = (i_MDU_op == OP_DIV) || (i_MDU_op == OP_DIVU);
  assign w_signed    = (i_MDU_op == OP_MULT) || (i_MDU_op == OP_DIV);
  assign w_a_neg     = w_signed && i_MDU_srcA[DATA_W-1];
  assign w_b_neg     = w_signed && i_MDU_srcB[DATA_W-1];
  // Negating 0x80000000 yields 0x80000000, read as an unsigned magnitude.
  assign w_mag_a     = w_a_neg ? -i_MDU_srcA : i_MDU_srcA;
  assign w_mag_b     = w_b_neg ? -i_MDU_srcB : i_MDU_srcB;

  // One multiply or divide step; r_acc holds {partial, shifting operand}.
  always_comb begin
    w_acc_next = r_acc;
    w_add      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} +
                 (r_acc[0] ? {1'b0, r_opd} : {(DATA_W+1){1'b0}});
    w_rem_sh   = r_acc[2*DATA_W-1:DATA_W-1];
    w_ge       = (w_rem_sh >= {1'b0, r_opd});
    w_diff     = r_acc[2*DATA_W-2:DATA_W-1] - r_opd;
    if (r_is_div) begin
      if (w_ge) begin
        w_acc_next = {w_diff, r_acc[DATA_W-2:0], 1'b1};
      end else begin
        w_acc_next = {r_acc[2*DATA_W-2:0], 1'b0};
      end
    end else begin
      w_acc_next = {w_add, r_acc[DATA_W-1:1]};
    end
  end

  assign w_prod = r_neg_res ? -r_acc : r_acc;

  // Final sign correction and the divide-by-zero override.
  always_comb begin
    w_res_hi = w_prod[2*DATA_W-1:DATA_W];
    w_res_lo = w_prod[DATA_W-1:0];
    if (r_div_zero) begin
      w_res_hi = r_raw_a;
      w_res_lo = {DATA_W{1'b1}};
    end else if (r_is_div) begin
      w_res_lo = r_neg_res ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
      w_res_hi = r_neg_rem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
    end else begin
      w_res_hi = w_prod[2*DATA_W-1:DATA_W];
      w_res_lo = w_prod[DATA_W-1:0];
    end
  end

  // Control FSM, datapath registers and HI/LO.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opd      <= '0;
      r_raw_a    <= '0;
      r_acc      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_RUN;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_is_div   <= w_is_div_op;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg && w_is_div_op;
            r_div_zero <= w_is_div_op && (i_MDU_srcB == '0);
            r_raw_a    <= i_MDU_srcA;
            r_opd      <= w_is_div_op ? w_mag_b : w_mag_a;
            r_acc      <= {{DATA_W{1'b0}}, (w_is_div_op ? w_mag_a : w_mag_b)};
          end else if (i_MDU_start && (i_MDU_op == OP_MTHI)) begin
            r_hi <= i_MDU_srcA;
          end else if (i_MDU_start && (i_MDU_op == OP_MTLO)) begin
            r_lo <= i_MDU_srcA;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_MDU_busy = r_busy;
  assign o_MDU_done = r_done;
  assign o_MDU_hi   = r_hi;
  assign o_MDU_lo   = r_lo;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the multicycle CPU, next to the ALU.
- Takes the same srcA/srcB operand buses as the ALU and produces the HI/LO architectural registers.
- The writeback mux reads HI/LO for MFHI/MFLO.
- The control FSM starts an operation, holds in EX while busy, and advances on done.

Parameters:
- DATA_W, 32, operand width. HI/LO are each DATA_W bits; iteration count equals DATA_W.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_MDU_srcA  input  32  dividend / multiplicand / MTHI-MTLO source.
- i_MDU_srcB  input  32  divisor / multiplier.
- i_MDU_op  input  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP.
- i_MDU_start  input  1  request, qualified with i_MDU_op.
- o_MDU_busy  output  1  iterative operation in progress.
- o_MDU_done  output  1  one-cycle pulse when HI/LO have been updated by MULT/DIV.
- o_MDU_hi  output  32  HI register.
- o_MDU_lo  output  32  LO register.

Behaviour:
- Clock and reset: one clock (i_clk). Reset i_rst is synchronous and active-high.
- Reset values: o_MDU_hi=0, o_MDU_lo=0, o_MDU_busy=0, o_MDU_done=0, FSM in IDLE.
- Reset mid-operation aborts the operation: no done pulse, and HI/LO are cleared.
- FSM states:
  - IDLE: waiting for a request.
  - RUN: 32 iterations, counter 0..31.
  - FIX: sign correction and HI/LO write.
- Accept rule: on an edge T0 where i_MDU_start=1, state=IDLE and op is 1..4:
  - Latch the operands.
  - For signed ops, latch the magnitudes plus the result-sign flags.
  - Go to RUN; busy=1 from the cycle after T0.
- RUN: one iteration per edge, T1..T32. After T32, go to FIX.
- FIX (edge T33):
  - Write HI/LO.
  - busy=0, done=1 for exactly one cycle, return to IDLE.
  - Total: busy is high 33 cycles; the result is visible in the cycle done is high.
- HI/LO visibility: they hold their old values throughout RUN and are never partially updated.
- Multiply: shift-add on unsigned magnitudes, 64-bit product, HI=product[63:32], LO=product[31:0].
  - MULT: if the operand signs differ, negate the 64-bit product (two's complement).
  - MULTU: no sign handling.
- Divide: restoring, one quotient bit per iteration on unsigned magnitudes.
  - LO=quotient, HI=remainder.
  - DIV: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - |0x80000000| is treated as unsigned 0x80000000.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=srcA unmodified. No trap; latency unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO:
  - When IDLE with start=1, write srcA into HI (MTHI) or LO (MTLO) at that edge.
  - busy stays 0; no done pulse.
- Ignored requests:
  - Any start while busy, including MTHI/MTLO; the in-flight operation is unaffected.
  - Ops 0 and 7 are no-ops.
- Operand stability: srcA/srcB are sampled only at the accept edge and may change afterwards.
- Back-to-back: a new start may be accepted in the cycle done=1 (state is IDLE then).
- Outputs o_MDU_hi/o_MDU_lo are registers, with no combinational path from the inputs.

Test Plan:
1. MULTU srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> busy for 33 cycles; done pulses once; HI=0xFFFFFFFE, LO=0x00000001.
2. MULT srcA=0xFFFFFFFD (-3), srcB=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
3. DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
   - Then DIVU srcA=7, srcB=0 -> LO=0xFFFFFFFF, HI=7.
4. DIV srcA=0x80000000, srcB=0xFFFFFFFF -> LO=0x80000000, HI=0.
   - DIVU 100/7 -> LO=14, HI=2.
5. Idle MTLO srcA=0x12345678 -> LO=0x12345678 after one edge, HI unchanged, busy/done stay 0.
   - Then start MULTU 3*5; mid-run, issue MTHI and a second start (DIVU 9/3) -> both ignored; final HI=0, LO=15.
6. Start DIVU 1000/10, assert i_rst at cycle 10 of RUN -> next cycle busy=0, HI=LO=0; no done pulse ever appears.
   - Immediately afterwards MULTU 2*3 completes normally with LO=6.
